// File: rtl/nbank_rd_buffer.sv
// nbank_rd_buffer
//   Multi-bank read buffer filled from DDR over an AXI read-master port.
//   A fill request reads one burst into the bank at the target pointer.
//   When the burst completes that bank becomes FULL and the pointer moves to
//   the next bank. The consumer reads words from any bank and releases FULL
//   banks back to EMPTY so they can be refilled.
//
// Ports
//   clk, rst_n       : sole clock, asynchronous active-low reset
//   fill_start       : fill request pulse, taken only while fill_ready=1
//   fill_addr        : DDR byte address of the burst
//   fill_len         : burst length minus one
//   fill_ready       : idle and the target bank is EMPTY
//   fill_done        : one-cycle pulse when a burst has been absorbed
//   fill_bank        : bank being filled, or the last bank filled
//   bank_full        : one bit per bank, set while that bank is FULL
//   rd_en/rd_bank/rd_addr -> rd_data : registered read, one cycle latency
//   rel_valid/rel_bank : release a FULL bank back to EMPTY
//   m_axi_*          : AXI read address and read data channels
//
// Optional build macro NBANK_RD_BUFFER_RESP_ERR_EN adds the bank_err output:
//   a per-bank sticky flag for error responses or a short/long burst, cleared
//   on release of that bank.

module nbank_rd_buffer #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned BANK_DEPTH = 1024,
    parameter int unsigned DW         = 64,
    parameter int unsigned AW         = 29,
    parameter int unsigned LEN_W      = 8,
    localparam int unsigned BA_W      = $clog2(BANK_DEPTH),
    localparam int unsigned BK_W      = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // fill control
    input  logic                 fill_start,
    input  logic [AW-1:0]        fill_addr,
    input  logic [LEN_W-1:0]     fill_len,
    output logic                 fill_ready,
    output logic                 fill_done,
    output logic [BK_W-1:0]      fill_bank,
    // consumer side
    output logic [NUM_BANKS-1:0] bank_full,
    input  logic                 rd_en,
    input  logic [BK_W-1:0]      rd_bank,
    input  logic [BA_W-1:0]      rd_addr,
    output logic [DW-1:0]        rd_data,
    input  logic                 rel_valid,
    input  logic [BK_W-1:0]      rel_bank,
`ifdef NBANK_RD_BUFFER_RESP_ERR_EN
    output logic [NUM_BANKS-1:0] bank_err,
`endif
    // AXI read master
    output logic [3:0]           m_axi_arid,
    output logic [AW-1:0]        m_axi_araddr,
    output logic [LEN_W-1:0]     m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [DW-1:0]        m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic [3:0]           m_axi_rid,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} fill_state_e;
    typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull} bank_state_e;

    // Beat counter is wide enough to hold both any bank index and any burst
    // length; it saturates so an endless burst cannot wrap back into the bank.
    localparam int unsigned     CW        = ((BA_W > LEN_W) ? BA_W : LEN_W) + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(BANK_DEPTH);
    localparam logic [BK_W:0]   NB_C      = (BK_W + 1)'(NUM_BANKS);
    localparam logic [BK_W-1:0] LAST_BANK = BK_W'(NUM_BANKS - 1);
    localparam logic [2:0]      AR_SIZE   = 3'($clog2(DW / 8));

    fill_state_e     state_q;
    bank_state_e     bank_st_q [NUM_BANKS];
    logic [BK_W-1:0] tgt_q;
    logic [BK_W-1:0] fill_bank_q;
    logic [AW-1:0]   araddr_q;
    logic [LEN_W-1:0] arlen_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            fill_done_q;
    logic [CW-1:0]   beat_idx_q;
    logic [DW-1:0]   rd_data_q;
    logic [DW-1:0]   mem [NUM_BANKS][BANK_DEPTH];

    logic accept;
    logic beat;
    logic rel_ok;

    // Ready depends on registered state only, so a release landing in the
    // same cycle as a fill request cannot make that request succeed.
    assign fill_ready = (state_q == StIdle) && (bank_st_q[tgt_q] == BkEmpty);
    assign accept     = fill_start && fill_ready;
    assign beat       = (state_q == StData) && m_axi_rvalid && rready_q;
    assign rel_ok     = rel_valid && ({1'b0, rel_bank} < NB_C) &&
                        (bank_st_q[rel_bank] == BkFull);

    // Fill FSM and per-bank state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                bank_st_q[i] <= BkEmpty;
            end
            tgt_q       <= '0;
            fill_bank_q <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            fill_done_q <= 1'b0;
            beat_idx_q  <= '0;
        end else begin
            fill_done_q <= 1'b0;
            // Only FULL banks are released; the FSM only touches EMPTY or
            // FILLING banks, so these updates never collide.
            if (rel_ok) begin
                bank_st_q[rel_bank] <= BkEmpty;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        araddr_q         <= fill_addr;
                        arlen_q          <= fill_len;
                        bank_st_q[tgt_q] <= BkFilling;
                        fill_bank_q      <= tgt_q;
                        beat_idx_q       <= '0;
                        arvalid_q        <= 1'b1;
                        state_q          <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (beat) begin
                        if (beat_idx_q != '1) begin
                            beat_idx_q <= beat_idx_q + 1'b1;
                        end
                        // rlast ends the burst whatever the beat count was
                        if (m_axi_rlast) begin
                            rready_q    <= 1'b0;
                            fill_done_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    bank_st_q[tgt_q] <= BkFull;
                    tgt_q            <= (tgt_q == LAST_BANK) ? '0 : tgt_q + 1'b1;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bank storage: beats past the end of the bank are accepted but dropped.
    always_ff @(posedge clk) begin
        if (beat && (beat_idx_q < DEPTH_C)) begin
            mem[tgt_q][beat_idx_q[BA_W-1:0]] <= m_axi_rdata;
        end
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= ({1'b0, rd_bank} < NB_C) ? mem[rd_bank][rd_addr] : '0;
        end
    end

`ifdef NBANK_RD_BUFFER_RESP_ERR_EN
    logic [NUM_BANKS-1:0] bank_err_q;
    logic                 beat_bad;

    assign beat_bad = (m_axi_rresp != 2'b00) ||
                      (m_axi_rlast && (beat_idx_q != CW'(arlen_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_err_q <= '0;
        end else begin
            if (rel_ok) begin
                bank_err_q[rel_bank] <= 1'b0;
            end
            if (beat && beat_bad) begin
                bank_err_q[tgt_q] <= 1'b1;
            end
        end
    end

    assign bank_err = bank_err_q;

    logic unused_in;
    assign unused_in = ^m_axi_rid;
`else
    logic unused_in;
    assign unused_in = ^{m_axi_rid, m_axi_rresp};
`endif

    always_comb begin
        bank_full = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            bank_full[i] = (bank_st_q[i] == BkFull);
        end
    end

    assign fill_done     = fill_done_q;
    assign fill_bank     = fill_bank_q;
    assign rd_data       = rd_data_q;
    assign m_axi_arid    = 4'd0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: doc/nbank_rd_buffer.md
NBANK_RD_BUFFER -- requirements
Module: nbank_rd_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of buffer banks (2..8).
REQ-002 SHALL have parameter BANK_DEPTH, default 1024, words per bank (power of 2); BA_W = $clog2(BANK_DEPTH), BK_W = max(1,$clog2(NUM_BANKS)).
REQ-003 SHALL have parameters DW 64 (data width), AW 29 (DDR address width), LEN_W 8 (burst length width).
REQ-004 SHALL have ports: clk in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have fill ports: fill_start in 1 (request pulse); fill_addr in AW (DDR byte address); fill_len in LEN_W (beats-1); fill_ready out 1; fill_done out 1 (one-cycle pulse); fill_bank out BK_W (bank being or last filled).
REQ-006 SHALL have consumer ports: bank_full out NUM_BANKS; rd_en in 1; rd_bank in BK_W; rd_addr in BA_W; rd_data out DW; rel_valid in 1; rel_bank in BK_W.
REQ-007 SHALL have AXI read-master ports: m_axi_arid out 4, araddr out AW, arlen out LEN_W, arsize out 3, arburst out 2, arvalid out 1, arready in 1, rdata in DW, rresp in 2, rid in 4, rlast in 1, rvalid in 1, rready out 1.

Function
REQ-008 SHALL keep per-bank state EMPTY/FILLING/FULL; bank_full[i]=1 only in FULL.
REQ-009 SHALL run fill FSM IDLE -> ADDR -> DATA -> DONE -> IDLE.
REQ-010 SHALL assert fill_ready = (FSM IDLE) AND (bank at target pointer tgt is EMPTY), from registered state only.
REQ-011 SHALL, on fill_start while fill_ready: latch fill_addr/fill_len, mark bank tgt FILLING, fill_bank<=tgt, go ADDR; fill_start without fill_ready SHALL be ignored.
REQ-012 SHALL in ADDR drive arvalid=1, araddr/arlen latched, arid=0, arsize=$clog2(DW/8), arburst=2'b01; arvalid SHALL stay high with stable payload until arready; then DATA.
REQ-013 SHALL in DATA drive rready=1; each beat (rvalid&rready) SHALL write rdata to bank tgt at beat index, index starting 0.
REQ-014 SHALL discard (not write) beats with index >= BANK_DEPTH while still accepting them.
REQ-015 SHALL end DATA on the beat with rlast=1 regardless of beat count; go DONE.
REQ-016 SHALL in DONE pulse fill_done one cycle, mark bank FULL, advance tgt = (tgt+1) mod NUM_BANKS, return IDLE.
REQ-017 SHALL return rd_data = bank[rd_bank][rd_addr] one cycle after rd_en=1; rd_data SHALL hold when rd_en=0; reads of any bank state allowed.
REQ-018 SHALL on rel_valid with rel_bank FULL set that bank EMPTY next cycle; release of EMPTY/FILLING bank or rel_bank >= NUM_BANKS SHALL be ignored.
REQ-019 SHALL, when release of bank tgt and fill_start coincide, reject the fill (fill_ready still 0 that cycle); fill accepted next cycle.
REQ-020 SHALL ignore m_axi_rid; rvalid outside DATA SHALL not write any bank.

Reset
REQ-021 SHALL on rst_n=0, immediately: FSM IDLE, all banks EMPTY, tgt=0, fill_bank=0, fill_done=0, arvalid=0, rready=0, araddr/arlen=0, bank_full=0, rd_data=0.
REQ-022 SHALL, if reset asserts mid-burst, abandon it; bank contents undefined, states EMPTY; no fill_done.
REQ-023 SHALL leave fill_ready=1 on the first cycle after reset release.

Configuration
REQ-024 SHALL with macro NBANK_RD_BUFFER_RESP_ERR_EN defined add output bank_err NUM_BANKS: set for bank tgt on any DATA beat with rresp!=2'b00 or rlast beat index != latched fill_len, cleared when that bank is released or reset.
REQ-025 SHALL without NBANK_RD_BUFFER_RESP_ERR_EN have no bank_err port and ignore rresp.

Verification
REQ-026 Reset release, NUM_BANKS=2: fill_start addr 0x100 len 3, 4 beats D0..D3 -> arlen=3, araddr=0x100, fill_done once, bank_full=01, rd bank0 addr2 returns D2 next cycle.
REQ-027 Two fills without release -> bank_full=11, fill_ready=0; third fill_start ignored, no arvalid.
REQ-028 Release bank0 same cycle as fill_start -> fill rejected; retry next cycle accepted into bank0.
REQ-029 BANK_DEPTH=4, fill_len=7, 8 beats -> all 8 accepted, rready high, bank words 0..3 = first four beats, fill_done.
REQ-030 arready held 0 five cycles -> arvalid and araddr stable all five; rst_n pulse during DATA -> all states EMPTY, no fill_done.
REQ-031 With NBANK_RD_BUFFER_RESP_ERR_EN, rresp=2'b10 on beat 1 -> bank_err[0]=1 after fill_done, cleared after release bank0.
